// File: rtl/vga_tile_color_source.sv
// rtl/vga_tile_color_source.sv - pixel colour source (tile map / bars / checker) feeding the VGA sync stage
// Tracks position from registered sync edges; tile map writes are open only during vertical blanking.
module vga_tile_color_source #(
  parameter int H_BACK     = 48,
  parameter int H_VISIBLE  = 640,
  parameter int V_BACK     = 33,
  parameter int V_VISIBLE  = 480,
  parameter int TILE_SHIFT = 5,
  parameter int TILES_X    = 20,
  parameter int TILES_Y    = 15,
  parameter int ADDR_W     = 9
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iPixelEnable,
  input  logic              iHsync,
  input  logic              iVsync,
  input  logic [1:0]        iMode,
  input  logic              iWrValid,
  input  logic [ADDR_W-1:0] iWrAddr,
  input  logic [2:0]        iWrColor,
  output logic              oWrReady,
  output logic              oWrError,
  output logic [2:0]        oColor,
  output logic              oVisible
);

  localparam int NTILES = TILES_X * TILES_Y;
  localparam int BAR_W  = H_VISIBLE / 8;

  localparam logic [10:0]       L_H_START = 11'(H_BACK);
  localparam logic [10:0]       L_H_END   = 11'(H_BACK + H_VISIBLE);
  localparam logic [9:0]        L_V_START = 10'(V_BACK);
  localparam logic [9:0]        L_V_END   = 10'(V_BACK + V_VISIBLE);
  localparam logic [ADDR_W-1:0] L_NTILES  = ADDR_W'(NTILES);
  localparam logic [ADDR_W-1:0] L_LAST    = ADDR_W'(NTILES - 1);

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_ptr;

  logic        r_hs_cur, r_hs_prev, r_vs_cur, r_vs_prev;
  logic [10:0] r_col;
  logic [9:0]  r_line;

  logic              r_wr_ready, r_wr_error;
  logic              r_s1_vis, r_s1_chk;
  logic [1:0]        r_s1_mode;
  logic [ADDR_W-1:0] r_s1_addr;
  logic [2:0]        r_s1_bar;
  logic [2:0]        r_color;
  logic              r_visible;

  logic [2:0] r_tile_mem [0:NTILES-1];

  logic              w_hs_rise, w_vs_rise;
  logic              w_h_in, w_v_in, w_vis, w_vblank;
  logic [10:0]       w_x, w_tx;
  logic [9:0]        w_y, w_ty;
  logic [ADDR_W-1:0] w_tile_addr;
  logic              w_chk;
  logic [2:0]        w_bar;
  logic              w_accept, w_in_range, w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [2:0]        w_wdata;
  logic [2:0]        w_pix;

  // Edge detectors idle high so a sync held high out of reset never fires.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_hs_cur  <= 1'b1;
      r_hs_prev <= 1'b1;
      r_vs_cur  <= 1'b1;
      r_vs_prev <= 1'b1;
    end else begin
      r_hs_cur  <= iHsync;
      r_hs_prev <= r_hs_cur;
      r_vs_cur  <= iVsync;
      r_vs_prev <= r_vs_cur;
    end
  end

  assign w_hs_rise = !r_hs_prev && r_hs_cur;
  assign w_vs_rise = !r_vs_prev && r_vs_cur;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_col  <= '0;
      r_line <= '0;
    end else if (w_hs_rise || w_vs_rise) begin
      if (w_hs_rise) r_col <= '0;
      if (w_vs_rise) r_line <= '0;
      else if (r_line != 10'h3FF) r_line <= r_line + 10'd1;
    end else if (iPixelEnable && r_col != 11'h7FF) begin
      r_col <= r_col + 11'd1;
    end
  end

  assign w_h_in      = (r_col >= L_H_START) && (r_col < L_H_END);
  assign w_v_in      = (r_line >= L_V_START) && (r_line < L_V_END);
  assign w_vis       = w_h_in && w_v_in;
  assign w_vblank    = !w_v_in;
  assign w_x         = r_col - L_H_START;
  assign w_y         = r_line - L_V_START;
  assign w_tx        = w_x >> TILE_SHIFT;
  assign w_ty        = w_y >> TILE_SHIFT;
  assign w_tile_addr = w_vis ? ADDR_W'(w_ty * TILES_X + w_tx) : '0;
  assign w_chk       = w_tx[0] ^ w_ty[0];

  // Bar index counts how many bar boundaries x has passed.
  always_comb begin
    w_bar = '0;
    for (int k = 1; k < 8; k++) begin
      if (w_x >= 11'(k * BAR_W)) w_bar = w_bar + 3'd1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= ST_CLEAR;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_CLEAR) r_ptr <= r_ptr + 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_in_range   = iWrAddr < L_NTILES;
    w_we         = 1'b0;
    w_waddr      = iWrAddr;
    w_wdata      = iWrColor;
    case (r_state)
      ST_CLEAR: begin
        w_we    = !Reset;
        w_waddr = r_ptr;
        w_wdata = 3'b000;
        if (r_ptr == L_LAST) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        w_accept = iWrValid && r_wr_ready && !Reset;
        w_we     = w_accept && w_in_range;
      end
      default: w_state_next = ST_CLEAR;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_wr_ready <= 1'b0;
      r_wr_error <= 1'b0;
    end else begin
      r_wr_ready <= (w_state_next == ST_RUN) && w_vblank;
      r_wr_error <= w_accept && !w_in_range;
    end
  end

  always_ff @(posedge Clock) begin
    if (w_we) r_tile_mem[w_waddr] <= w_wdata;
  end

  // Stage 1 is gated by RUN so nothing visible leaves the pipe while clearing.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_s1_vis  <= 1'b0;
      r_s1_mode <= '0;
      r_s1_addr <= '0;
      r_s1_bar  <= '0;
      r_s1_chk  <= 1'b0;
    end else begin
      r_s1_vis  <= w_vis && (r_state == ST_RUN);
      r_s1_mode <= iMode;
      r_s1_addr <= w_tile_addr;
      r_s1_bar  <= w_bar;
      r_s1_chk  <= w_chk;
    end
  end

  always_comb begin
    w_pix = 3'b000;
    case (r_s1_mode)
      2'd0:    w_pix = r_tile_mem[r_s1_addr];
      2'd1:    w_pix = r_s1_bar;
      2'd2:    w_pix = {3{r_s1_chk}};
      default: w_pix = 3'b000;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_color   <= '0;
      r_visible <= 1'b0;
    end else begin
      r_visible <= r_s1_vis;
      r_color   <= r_s1_vis ? w_pix : 3'b000;
    end
  end

  assign oWrReady = r_wr_ready;
  assign oWrError = r_wr_error;
  assign oColor   = r_color;
  assign oVisible = r_visible;

endmodule

// File: tb/tb_vga_tile_color_source.sv
// tb/tb_vga_tile_color_source.sv - bench for vga_tile_color_source with a position/tile-map reference model
module tb_vga_tile_color_source;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       iPixelEnable = 1'b0;
  logic       iHsync = 1'b1;
  logic       iVsync = 1'b1;
  logic [1:0] iMode = 2'd0;
  logic       iWrValid = 1'b0;
  logic [8:0] iWrAddr = '0;
  logic [2:0] iWrColor = '0;
  logic       oWrReady, oWrError, oVisible;
  logic [2:0] oColor;

  always #5 Clock = ~Clock;

  vga_tile_color_source dut (
    .Clock(Clock), .Reset(Reset), .iPixelEnable(iPixelEnable),
    .iHsync(iHsync), .iVsync(iVsync), .iMode(iMode),
    .iWrValid(iWrValid), .iWrAddr(iWrAddr), .iWrColor(iWrColor),
    .oWrReady(oWrReady), .oWrError(oWrError), .oColor(oColor), .oVisible(oVisible)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, plain integers.
  bit m_on = 0;
  int m_hs_cur, m_hs_prev, m_vs_cur, m_vs_prev;
  int m_col, m_line, m_run, m_cnt, m_ready, m_err, m_color, m_vis;
  int m_s1_vis, m_s1_mode, m_s1_x, m_s1_y;
  int m_tile [0:299];

  typedef struct {
    int mode;
    int line;
    int col;
    int exp_color;
    int exp_vis;
  } vec_t;

  vec_t vt [12];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pix(input int mode, input int x, input int y);
    case (mode)
      0:       return m_tile[(y / 32) * 20 + (x / 32)];
      1:       return x / 80;
      2:       return (((x / 32) + (y / 32)) % 2 == 1) ? 7 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic void model_update();
    int hs_rise, vs_rise, acc, n_color, n_vis, n_err, n_ready, vis_now;
    if (Reset) begin
      m_on = 1;
      m_hs_cur = 1; m_hs_prev = 1; m_vs_cur = 1; m_vs_prev = 1;
      m_col = 0; m_line = 0; m_run = 0; m_cnt = 0;
      m_ready = 0; m_err = 0; m_color = 0; m_vis = 0;
      m_s1_vis = 0; m_s1_mode = 0; m_s1_x = 0; m_s1_y = 0;
      return;
    end
    if (!m_on) return;
    hs_rise = (m_hs_prev == 0 && m_hs_cur == 1);
    vs_rise = (m_vs_prev == 0 && m_vs_cur == 1);
    n_vis   = m_s1_vis;
    n_color = m_s1_vis ? pix(m_s1_mode, m_s1_x, m_s1_y) : 0;
    vis_now = m_run && m_col >= 48 && m_col < 688 && m_line >= 33 && m_line < 513;
    m_s1_vis = vis_now; m_s1_mode = int'(iMode);
    m_s1_x = m_col - 48; m_s1_y = m_line - 33;
    acc   = iWrValid && m_ready;
    n_err = acc && (iWrAddr >= 300);
    if (acc && iWrAddr < 300) m_tile[iWrAddr] = int'(iWrColor);
    if (!m_run) begin
      m_tile[m_cnt] = 0;
      m_cnt++;
      if (m_cnt == 300) m_run = 1;
    end
    n_ready = m_run && (m_line < 33 || m_line >= 513);
    if (hs_rise || vs_rise) begin
      if (hs_rise) m_col = 0;
      if (vs_rise) m_line = 0;
      else if (m_line < 1023) m_line++;
    end else if (iPixelEnable && m_col < 2047) begin
      m_col++;
    end
    m_hs_prev = m_hs_cur; m_hs_cur = int'(iHsync);
    m_vs_prev = m_vs_cur; m_vs_cur = int'(iVsync);
    m_color = n_color; m_vis = n_vis; m_err = n_err; m_ready = n_ready;
  endfunction

  task automatic step();
    @(posedge Clock);
    model_update();
    #1;
    if (m_on) begin
      check("model_color", int'(oColor), m_color);
      check("model_visible", int'(oVisible), m_vis);
      check("model_wr_ready", int'(oWrReady), m_ready);
      check("model_wr_error", int'(oWrError), m_err);
    end
  endtask

  // Coincident sync pulse zeroes col and line, then line hsyncs and col pixel ticks.
  task automatic goto(input int line, input int col);
    iPixelEnable = 0;
    iHsync = 0; iVsync = 0; step();
    iHsync = 1; iVsync = 1; step();
    for (int i = 0; i < line; i++) begin
      iHsync = 0; step();
      iHsync = 1; step();
    end
    step();
    iPixelEnable = 1;
    for (int i = 0; i < col; i++) step();
    iPixelEnable = 0;
    step(); step();
  endtask

  task automatic count_clear(input string name);
    int n = 0;
    while (!oWrReady && n < 1000) begin
      step();
      n++;
    end
    check(name, n, 300);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    bit acc;
    for (int i = 0; i < 300; i++) m_tile[i] = 0;

    vt[0]  = '{0, 100, 300, 0, 1};
    vt[1]  = '{0, 65, 80, 5, 1};
    vt[2]  = '{0, 65, 79, 0, 1};
    vt[3]  = '{1, 40, 48, 0, 1};
    vt[4]  = '{1, 40, 127, 0, 1};
    vt[5]  = '{1, 40, 128, 1, 1};
    vt[6]  = '{1, 40, 687, 7, 1};
    vt[7]  = '{1, 40, 47, 0, 0};
    vt[8]  = '{1, 40, 688, 0, 0};
    vt[9]  = '{2, 33, 48, 0, 1};
    vt[10] = '{2, 33, 80, 7, 1};
    vt[11] = '{2, 65, 80, 0, 1};

    Reset = 1; step();
    check("reset_color", int'(oColor), 0);
    check("reset_visible", int'(oVisible), 0);
    check("reset_wr_ready", int'(oWrReady), 0);
    check("reset_wr_error", int'(oWrError), 0);
    Reset = 0;
    count_clear("clear_cycles");

    iWrValid = 1; iWrAddr = 9'd21; iWrColor = 3'b101;
    n = 0;
    while (!oWrReady && n < 100) begin step(); n++; end
    check("write21_ready", int'(oWrReady), 1);
    step();
    iWrValid = 0;

    for (int i = 0; i < 12; i++) begin
      iMode = 2'(vt[i].mode);
      goto(vt[i].line, vt[i].col);
      check($sformatf("vec%0d_color", i), int'(oColor), vt[i].exp_color);
      check($sformatf("vec%0d_visible", i), int'(oVisible), vt[i].exp_vis);
    end

    goto(0, 0);
    iWrValid = 1; iWrAddr = 9'd300; iWrColor = 3'b010;
    check("oob_ready", int'(oWrReady), 1);
    step();
    iWrValid = 0;
    check("oob_error_pulse", int'(oWrError), 1);
    step();
    check("oob_error_clear", int'(oWrError), 0);
    iMode = 2'd0;
    goto(65, 80);
    check("oob_tile21_kept", int'(oColor), 5);

    goto(100, 0);
    iWrValid = 1; iWrAddr = 9'd42; iWrColor = 3'b011;
    for (int i = 0; i < 5; i++) begin
      step();
      check("blocked_ready", int'(oWrReady), 0);
    end
    iVsync = 0; step();
    iVsync = 1; step();
    n = 0;
    while (!oWrReady && n < 20) begin step(); n++; end
    check("unblocked_ready", int'(oWrReady), 1);
    step();
    iWrValid = 0;
    goto(97, 112);
    check("tile42_color", int'(oColor), 3);

    goto(10, 20);
    iPixelEnable = 1;
    iHsync = 0; iVsync = 0; step();
    iHsync = 1; iVsync = 1; step();
    step();
    check("coinc_col", int'(dut.r_col), 0);
    check("coinc_line", int'(dut.r_line), 0);
    iPixelEnable = 0;

    Reset = 1; step();
    Reset = 0;
    for (int i = 0; i < 150; i++) step();
    check("mid_clear_ptr", int'(dut.r_ptr), 150);
    Reset = 1; step();
    check("restart_ptr", int'(dut.r_ptr), 0);
    Reset = 0;
    count_clear("reclear_cycles");

    for (int it = 0; it < 12; it++) begin
      iMode = 2'($urandom_range(0, 3));
      goto($urandom_range(20, 540), 0);
      for (int c = 0; c < 700; c++) begin
        iPixelEnable = ($urandom_range(0, 4) != 0);
        iHsync = ($urandom_range(0, 249) != 0);
        iVsync = ($urandom_range(0, 2999) != 0);
        if ($urandom_range(0, 99) == 0) iMode = 2'($urandom_range(0, 3));
        if (!iWrValid && $urandom_range(0, 5) == 0) begin
          iWrValid = 1;
          iWrAddr  = 9'($urandom_range(0, 319));
          iWrColor = 3'($urandom_range(0, 7));
        end
        acc = iWrValid && oWrReady;
        step();
        if (acc) iWrValid = 0;
      end
      iHsync = 1; iVsync = 1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
